midori_affine_inv_serial: RTL and testbench



---
 rtl/midori_affine_pkg.sv | 17 +
 rtl/midori_affine_inv_nibble.sv | 27 ++
 rtl/midori_affine_inv_serial.sv | 110 +++++++++++
 tb/tb_midori_affine_inv_serial.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midori_affine_pkg.sv
// Shared constants and types for the serial inverse Midori affine block.
package midori_affine_pkg;

    localparam logic [1:0] AFF_PASS = 2'd0;
    localparam logic [1:0] AFF_IN   = 2'd1;
    localparam logic [1:0] AFF_OUT  = 2'd2;
    localparam logic [1:0] AFF_MID  = 2'd3;

    localparam int NIBBLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/midori_affine_inv_nibble.sv
// One-nibble inverse affine for a single share; the share index selects
// whether the constant inversion of the output affine is applied.
module midori_affine_inv_nibble
    import midori_affine_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [1:0] share,
    input  logic [3:0] y,
    output logic [3:0] x
);

    logic cst;

    // Only share 1 carries the affine constant, so the masked sum sees it once.
    assign cst = (share == 2'd1);

    always_comb begin
        x = y;
        case (mode)
            AFF_IN:  x = {y[2], y[3] ^ y[1], y[0], y[1]};
            AFF_OUT: x = {y[2] ^ y[0], y[0], y[3] ^ cst, y[1]};
            AFF_MID: x = {y[0] ^ y[1], ~(y[3] ^ y[2]), y[1], y[2]};
            default: x = y;
        endcase
    end

endmodule

// File: rtl/midori_affine_inv_serial.sv
// Serial inverse affine over a 3-share 64-bit Midori state, LANES nibbles
// per cycle, transformed in place; shares never meet in any datapath.
module midori_affine_inv_serial
    import midori_affine_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  mode,
    input  logic [63:0] s1_in,
    input  logic [63:0] s2_in,
    input  logic [63:0] s3_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] s1_out,
    output logic [63:0] s2_out,
    output logic [63:0] s3_out
);

    localparam int ITER = NIBBLES / LANES;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    state_t                       state;
    logic [CW-1:0]                cnt;
    logic [1:0]                   mode_q;
    logic [2:0][63:0]             sh_q;
    logic [2:0][63:0]             sh_nx;
    logic [LANES-1:0][3:0]        lane_idx;
    logic [2:0][LANES-1:0][3:0]   y_n;
    logic [2:0][LANES-1:0][3:0]   x_n;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(int'(cnt) * LANES + l);
        end
    end

    always_comb begin
        for (int s = 0; s < 3; s++) begin
            for (int l = 0; l < LANES; l++) begin
                y_n[s][l] = sh_q[s][{lane_idx[l], 2'b00} +: 4];
            end
        end
    end

    for (genvar gs = 0; gs < 3; gs++) begin : g_share
        for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
            midori_affine_inv_nibble u_nib (
                .mode  (mode_q),
                .share (2'(gs + 1)),
                .y     (y_n[gs][gl]),
                .x     (x_n[gs][gl])
            );
        end
    end

    // Write the transformed lanes back over their own positions.
    always_comb begin
        sh_nx = sh_q;
        for (int s = 0; s < 3; s++) begin
            for (int l = 0; l < LANES; l++) begin
                sh_nx[s][{lane_idx[l], 2'b00} +: 4] = x_n[s][l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= AFF_PASS;
            sh_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_q   <= {s3_in, s2_in, s1_in};
                        mode_q <= mode;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sh_q <= sh_nx;
                    if (cnt == CW'(ITER - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign s1_out    = sh_q[0];
    assign s2_out    = sh_q[1];
    assign s3_out    = sh_q[2];

endmodule

// File: tb/tb_midori_affine_inv_serial.sv
// Bench for midori_affine_inv_serial: LANES=4 instance under a scoreboard,
// plus a LANES=1 instance for long latency and reset-during-RUN cases.
`timescale 1ns/1ps
module tb_midori_affine_inv_serial;

    localparam int W = 192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  mode;
    logic [63:0] s1_in, s2_in, s3_in, s1_out, s2_out, s3_out;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic [1:0]  mode_b;
    logic [63:0] s1_in_b, s2_in_b, s3_in_b, s1_out_b, s2_out_b, s3_out_b;

    logic [W-1:0]   exp_q[$];
    logic [W+1:0]   in_q[$];
    int             n_cmp = 0;
    int             n_err = 0;

    always #5 clk = ~clk;

    midori_affine_inv_serial #(.LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .s1_in(s1_in), .s2_in(s2_in), .s3_in(s3_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .s1_out(s1_out), .s2_out(s2_out), .s3_out(s3_out)
    );

    midori_affine_inv_serial #(.LANES(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .mode(mode_b), .s1_in(s1_in_b), .s2_in(s2_in_b), .s3_in(s3_in_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .s1_out(s1_out_b), .s2_out(s2_out_b), .s3_out(s3_out_b)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference maps, written straight from the per-bit equations.
    function automatic logic [3:0] inv_nib(input logic [1:0] m, input int sh, input logic [3:0] y);
        logic y3, y2, y1, y0;
        {y3, y2, y1, y0} = y;
        case (m)
            2'd1:    return {y2, y3 ^ y1, y0, y1};
            2'd2:    return {y2 ^ y0, y0, (sh == 1) ? ~y3 : y3, y1};
            2'd3:    return {y0 ^ y1, ~(y3 ^ y2), y1, y2};
            default: return y;
        endcase
    endfunction

    function automatic logic [3:0] fwd_nib(input logic [1:0] m, input int sh, input logic [3:0] x);
        logic x3, x2, x1, x0;
        {x3, x2, x1, x0} = x;
        case (m)
            2'd1:    return {x2 ^ x0, x3, x0, x1};
            2'd2:    return {(sh == 1) ? ~x1 : x1, x3 ^ x2, x0, x2};
            2'd3:    return {~(x2 ^ x0), x0, x1, x3 ^ x1};
            default: return x;
        endcase
    endfunction

    function automatic logic [63:0] inv64(input logic [1:0] m, input int sh, input logic [63:0] v);
        logic [63:0] r;
        for (int k = 0; k < 16; k++) r[4*k +: 4] = inv_nib(m, sh, v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] fwd64(input logic [1:0] m, input int sh, input logic [63:0] v);
        logic [63:0] r;
        for (int k = 0; k < 16; k++) r[4*k +: 4] = fwd_nib(m, sh, v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a state to the LANES=4 instance; expectations are queued on acceptance.
    task automatic send(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic rdy;
        bit   ok;
        mode = m; s1_in = a; s2_in = b; s3_in = c; in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) begin
                ok = 1;
                exp_q.push_back({inv64(m, 3, c), inv64(m, 2, b), inv64(m, 1, a)});
                in_q.push_back({m, c, b, a});
            end
            #1;
        end
        in_valid = 1'b0;
        mode = 2'($urandom_range(0, 3));
        s1_in = rand64(); s2_in = rand64(); s3_in = rand64();
        if (!ok) check("accept_timeout", W'(ok), W'(1));
    endtask

    task automatic send_b(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        logic rdy;
        bit   ok;
        mode_b = m; s1_in_b = a; s2_in_b = b; s3_in_b = c; in_valid_b = 1'b1;
        ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            rdy = in_ready_b;
            @(posedge clk);
            if (rdy) ok = 1;
            #1;
        end
        in_valid_b = 1'b0;
        s1_in_b = rand64(); s2_in_b = rand64(); s3_in_b = rand64();
        if (!ok) check("accept_b_timeout", W'(ok), W'(1));
    endtask

    // Called one step after the accepting edge, i.e. in cycle 1.
    task automatic wait_valid(input bit sel_b, output int lat);
        lat = 1;
        while (!(sel_b ? out_valid_b : out_valid) && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W+1:0] r;
        logic [63:0]  a, b, c;
        logic [1:0]   m;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", W'(exp_q.size()), W'(1));
            end else begin
                e = exp_q.pop_front();
                r = in_q.pop_front();
                {m, c, b, a} = r;
                check("shares", {s3_out, s2_out, s1_out}, e);
                check("xor_inv", W'(s1_out ^ s2_out ^ s3_out), W'(inv64(m, 1, a ^ b ^ c)));
                check("fwd_roundtrip", {fwd64(m, 3, s3_out), fwd64(m, 2, s2_out), fwd64(m, 1, s1_out)}, {c, b, a});
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() != 0) check("drain", W'(exp_q.size()), W'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [63:0] a, b, c, v;
        logic [W-1:0] exp_bp;

        rst_n = 1'b0; in_valid = 1'b0; mode = 2'd0; out_ready = 1'b1;
        s1_in = '0; s2_in = '0; s3_in = '0;
        in_valid_b = 1'b0; mode_b = 2'd0; out_ready_b = 1'b1;
        s1_in_b = '0; s2_in_b = '0; s3_in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_shares", {s3_out, s2_out, s1_out}, W'(0));
        check("rst_b_shares", {s3_out_b, s2_out_b, s1_out_b}, W'(0));
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Known vector: nibble 14 holds y=1, which must land on x=2.
        send(2'd1, 64'h0123456789ABCDEF, 64'h0, 64'h0);
        wait_valid(0, lat);
        check("latency_l4", W'(lat), W'(5));
        check("nib_y1", W'(s1_out[59:56]), W'(4'h2));
        check("nib_yF", W'(s1_out[3:0]), W'(inv_nib(2'd1, 1, 4'hF)));
        drain();

        send(2'd2, 64'h0, 64'h0, 64'h0);
        wait_valid(0, lat);
        check("m2_const", {s3_out, s2_out, s1_out}, {64'h0, 64'h0, 64'h2222222222222222});
        drain();

        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < ((m == 0) ? 100 : 1000); n++) begin
                v = rand64(); b = rand64(); c = rand64();
                send(2'(m), v ^ b ^ c, b, c);
                repeat ($urandom_range(0, 2)) tick();
            end
            drain();
        end

        // Backpressure: DONE held with a competing offer on the input.
        out_ready = 1'b0;
        a = rand64(); b = rand64(); c = rand64();
        exp_bp = {inv64(2'd1, 3, c), inv64(2'd1, 2, b), inv64(2'd1, 1, a)};
        send(2'd1, a, b, c);
        wait_valid(0, lat);
        check("latency_bp", W'(lat), W'(5));
        a = rand64(); b = rand64(); c = rand64();
        mode = 2'd3; s1_in = a; s2_in = b; s3_in = c; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", {s3_out, s2_out, s1_out}, exp_bp);
            check("bp_in_ready", W'(in_ready), W'(0));
            check("bp_out_valid", W'(out_valid), W'(1));
        end
        out_ready = 1'b1;
        send(2'd3, a, b, c);
        drain();

        // Asynchronous reset while holding a result in DONE.
        out_ready = 1'b0;
        send(2'd3, rand64(), rand64(), rand64());
        wait_valid(0, lat);
        #2 rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", W'(out_valid), W'(0));
        check("rst_done_in_ready", W'(in_ready), W'(1));
        check("rst_done_shares", {s3_out, s2_out, s1_out}, W'(0));
        exp_q.delete();
        in_q.delete();
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // LANES=1: full latency, then an abort in RUN cycle 7.
        a = rand64(); b = rand64(); c = rand64();
        send_b(2'd1, a, b, c);
        wait_valid(1, lat);
        check("latency_l1", W'(lat), W'(17));
        check("l1_shares", {s3_out_b, s2_out_b, s1_out_b}, {inv64(2'd1, 3, c), inv64(2'd1, 2, b), inv64(2'd1, 1, a)});
        tick();
        send_b(2'd3, rand64(), rand64(), rand64());
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_run_out_valid", W'(out_valid_b), W'(0));
        check("rst_run_in_ready", W'(in_ready_b), W'(1));
        check("rst_run_shares", {s3_out_b, s2_out_b, s1_out_b}, W'(0));
        @(negedge clk) rst_n = 1'b1;
        tick();
        a = rand64(); b = rand64(); c = rand64();
        send_b(2'd2, a, b, c);
        wait_valid(1, lat);
        check("post_rst_latency", W'(lat), W'(17));
        check("post_rst_shares", {s3_out_b, s2_out_b, s1_out_b}, {inv64(2'd2, 3, c), inv64(2'd2, 2, b), inv64(2'd2, 1, a)});
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
